// File: rtl/dmem_if.sv
// ---------------------------------------------------------------------------
// dmem_if
//   Request/response channel between the memory-access stage (master) and
//   the data-memory responder (slave).
//
//   Request  : req_valid/req_ready handshake, req_we (1 = store),
//              req_addr (byte address), req_wdata, req_be (byte enables)
//   Response : rsp_valid/rsp_ready handshake, rsp_rdata (load data),
//              rsp_err (misaligned or out-of-range access)
// ---------------------------------------------------------------------------
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//   Word-organised data memory that serves one load/store at a time with a
//   configurable number of wait states, so the memory-access stage can stall
//   on slow memory.
//
//   Parameters
//     DMEM_SIZE : depth in 32-bit words (word index = addr >> 2)
//     LATENCY   : wait cycles between accept and response, 0..15
//
//   Ports
//     CLK  : clock, all state changes on the rising edge
//     RST  : synchronous, active-low reset (memory contents are kept)
//     bus  : dmem_if slave side (request + response channels)
//     busy : high whenever a transaction is in flight (state != IDLE)
//
//   Timing: rsp_valid is first seen LATENCY+1 cycles after the accept edge;
//   a transaction occupies at least LATENCY+2 cycles. The access (store
//   write or load capture) happens on the edge that enters RESP.
// ---------------------------------------------------------------------------
module dmem_responder #(
  parameter int DMEM_SIZE = 1024,
  parameter int LATENCY   = 2
) (
  input  logic  CLK,
  input  logic  RST,
  dmem_if.slave bus,
  output logic  busy
);

  localparam int         AW  = (DMEM_SIZE > 1) ? $clog2(DMEM_SIZE) : 1;
  localparam logic [3:0] LAT = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;

  // Request captured at accept time
  logic        lat_we;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [3:0]  lat_be;

  // Registered response
  logic        rsp_valid_q;
  logic        rsp_err_q;
  logic [31:0] rsp_rdata_q;

  // NOTE: the storage array has no reset; clearing it would cost a write
  // port per word and the contents must survive RST anyway.
  logic [31:0] mem [DMEM_SIZE];

  // Access performed on the edge entering RESP. With LATENCY==0 that edge is
  // the accept edge itself, so the live request is used instead of the
  // captured copy.
  logic          c_fire;
  logic          c_we;
  logic          c_err;
  logic [31:0]   c_addr;
  logic [31:0]   c_wdata;
  logic [3:0]    c_be;
  logic [AW-1:0] c_idx;
  logic [31:0]   c_rdata;

  // NOTE: every signal gets a default at the top of the block so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    c_fire  = 1'b0;
    c_we    = lat_we;
    c_addr  = lat_addr;
    c_wdata = lat_wdata;
    c_be    = lat_be;
    if (state == IDLE && LAT == 4'd0) begin
      c_fire  = bus.req_valid && bus.req_ready;
      c_we    = bus.req_we;
      c_addr  = bus.req_addr;
      c_wdata = bus.req_wdata;
      c_be    = bus.req_be;
    end else if (state == WAIT && cnt == 4'd1) begin
      c_fire = 1'b1;
    end
    // Full 32-bit range check so high addresses never alias into the array.
    c_err   = (c_addr[1:0] != 2'b00) || ((c_addr >> 2) >= 32'(DMEM_SIZE));
    c_idx   = c_addr[AW+1:2];
    c_rdata = (c_we || c_err) ? 32'h0 : mem[c_idx];
  end

  // Store commit; gated by RST so a pending store is dropped by reset.
  always_ff @(posedge CLK) begin
    if (RST && c_fire && c_we && !c_err) begin
      for (int i = 0; i < 4; i++) begin
        if (c_be[i]) mem[c_idx][8*i +: 8] <= c_wdata[8*i +: 8];
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            lat_we    <= bus.req_we;
            lat_addr  <= bus.req_addr;
            lat_wdata <= bus.req_wdata;
            lat_be    <= bus.req_be;
            cnt       <= LAT;
            state     <= (LAT == 4'd0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state       <= IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
      // Response data is loaded once on entry to RESP and held until the
      // handshake, so it stays stable while the requester stalls.
      if (c_fire) begin
        rsp_valid_q <= 1'b1;
        rsp_rdata_q <= c_rdata;
        rsp_err_q   <= c_err;
      end
    end
  end

  assign bus.req_ready = RST && (state == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
//   Drives two responders (LATENCY=2 and LATENCY=0) and compares every
//   response against a word-array model of the memory.
// ---------------------------------------------------------------------------
module tb_dmem_responder;

  localparam int DMEM_SIZE = 1024;
  localparam int LAT_A     = 2;
  localparam int WIN       = 64;   // words preloaded and used for random traffic

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic busy_a, busy_b;

  dmem_if a_if ();
  dmem_if b_if ();

  dmem_responder #(.DMEM_SIZE(DMEM_SIZE), .LATENCY(LAT_A)) u_a (
    .CLK (CLK),
    .RST (RST),
    .bus (a_if.slave),
    .busy(busy_a)
  );

  dmem_responder #(.DMEM_SIZE(DMEM_SIZE), .LATENCY(0)) u_b (
    .CLK (CLK),
    .RST (RST),
    .bus (b_if.slave),
    .busy(busy_b)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  logic [31:0] ref_mem [DMEM_SIZE];
  logic [31:0] ref_b   [4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One transaction on DUT A. The model result is computed up front from
  // the address rules; 'hold' stalls rsp_ready while a stray store is
  // presented that must be ignored.
  task automatic txn_a(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input int hold);
    int          n;
    int          idx;
    logic        exp_err;
    logic [31:0] exp_rd;
    logic [31:0] rd0;
    exp_err = (addr[1:0] != 2'b00) || ((addr >> 2) >= 32'(DMEM_SIZE));
    exp_rd  = 32'h0;
    if (!exp_err) begin
      idx = int'(addr >> 2);
      if (we) begin
        for (int i = 0; i < 4; i++)
          if (be[i]) ref_mem[idx][8*i +: 8] = wdata[8*i +: 8];
      end else begin
        exp_rd = ref_mem[idx];
      end
    end

    @(negedge CLK);
    a_if.req_valid = 1'b1;
    a_if.req_we    = we;
    a_if.req_addr  = addr;
    a_if.req_wdata = wdata;
    a_if.req_be    = be;
    n = 0;
    while (!a_if.req_ready && n < 40) begin
      @(negedge CLK);
      n++;
    end
    check("req_ready", 32'(a_if.req_ready), 32'd1);
    @(negedge CLK);
    a_if.req_valid = 1'b0;
    n = 1;
    while (!a_if.rsp_valid && n < 40) begin
      @(negedge CLK);
      n++;
    end
    check("latency", 32'(n), 32'(LAT_A + 1));
    check("rdata", a_if.rsp_rdata, exp_rd);
    check("err", 32'(a_if.rsp_err), 32'(exp_err));
    rd0 = a_if.rsp_rdata;

    for (int h = 0; h < hold; h++) begin
      a_if.req_valid = 1'b1;
      a_if.req_we    = 1'b1;
      a_if.req_addr  = 32'h14;
      a_if.req_wdata = 32'hBAD0_BAD0;
      a_if.req_be    = 4'hF;
      @(negedge CLK);
      check("hold_valid", 32'(a_if.rsp_valid), 32'd1);
      check("hold_rdata", a_if.rsp_rdata, rd0);
      check("hold_ready", 32'(a_if.req_ready), 32'd0);
    end

    a_if.req_valid = 1'b0;
    a_if.rsp_ready = 1'b1;
    @(negedge CLK);
    a_if.rsp_ready = 1'b0;
    check("rsp_clear", 32'(a_if.rsp_valid), 32'd0);
    check("idle", 32'(busy_a), 32'd0);
  endtask

  initial begin
    logic [31:0] addr;
    logic        exp_err;

    a_if.req_valid = 1'b0; a_if.req_we = 1'b0; a_if.req_addr = '0;
    a_if.req_wdata = '0;   a_if.req_be = '0;   a_if.rsp_ready = 1'b0;
    b_if.req_valid = 1'b0; b_if.req_we = 1'b0; b_if.req_addr = '0;
    b_if.req_wdata = '0;   b_if.req_be = '0;   b_if.rsp_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge CLK);
    check("rst_ready", 32'(a_if.req_ready), 32'd0);
    check("rst_valid", 32'(a_if.rsp_valid), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_rdata", a_if.rsp_rdata, 32'h0);
    check("rst_err", 32'(a_if.rsp_err), 32'd0);
    check("rst_valid_b", 32'(b_if.rsp_valid), 32'd0);
    RST = 1'b1;
    @(negedge CLK);
    check("post_rst_ready", 32'(a_if.req_ready), 32'd1);

    // Preload the working window with zeros
    for (int w = 0; w < WIN; w++) txn_a(1'b1, 32'(w * 4), 32'h0, 4'hF, 0);

    // Store then load back
    txn_a(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0);
    txn_a(1'b0, 32'h10, 32'h0, 4'h0, 0);

    // Partial byte-enable merge, then an all-disabled store
    txn_a(1'b1, 32'h20, 32'h1122_3344, 4'hF, 0);
    txn_a(1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101, 0);
    txn_a(1'b0, 32'h20, 32'h0, 4'h0, 0);
    check("merge_model", ref_mem[8], 32'h11BB_33DD);
    txn_a(1'b1, 32'h20, 32'hFFFF_FFFF, 4'b0000, 0);
    txn_a(1'b0, 32'h20, 32'h0, 4'h0, 0);

    // Error cases: misaligned, one past the end, high address that would wrap
    txn_a(1'b0, 32'h22, 32'h0, 4'h0, 0);
    txn_a(1'b0, 32'(DMEM_SIZE * 4), 32'h0, 4'h0, 0);
    txn_a(1'b1, 32'h22, 32'h5555_5555, 4'hF, 0);
    txn_a(1'b1, 32'h8000_0010, 32'h6666_6666, 4'hF, 0);
    txn_a(1'b1, 32'(DMEM_SIZE * 4) + 32'h20, 32'h7777_7777, 4'hF, 0);
    txn_a(1'b0, 32'h20, 32'h0, 4'h0, 0);
    txn_a(1'b0, 32'h10, 32'h0, 4'h0, 0);

    // Stalled response with a stray request present; target word must stay 0
    txn_a(1'b0, 32'h10, 32'h0, 4'h0, 5);
    txn_a(1'b0, 32'h14, 32'h0, 4'h0, 0);

    // Reset during WAIT of a store: store is dropped, outputs clear
    @(negedge CLK);
    a_if.req_valid = 1'b1;
    a_if.req_we    = 1'b1;
    a_if.req_addr  = 32'h30;
    a_if.req_wdata = 32'h5;
    a_if.req_be    = 4'hF;
    check("abort_ready", 32'(a_if.req_ready), 32'd1);
    @(negedge CLK);
    a_if.req_valid = 1'b0;
    check("abort_busy", 32'(busy_a), 32'd1);
    RST = 1'b0;
    @(negedge CLK);
    check("abort_idle", 32'(busy_a), 32'd0);
    check("abort_valid", 32'(a_if.rsp_valid), 32'd0);
    check("abort_rdata", a_if.rsp_rdata, 32'h0);
    check("abort_rdy", 32'(a_if.req_ready), 32'd0);
    RST = 1'b1;
    @(negedge CLK);
    check("abort_valid2", 32'(a_if.rsp_valid), 32'd0);
    txn_a(1'b0, 32'h30, 32'h0, 4'h0, 0);

    // Randomized traffic
    for (int t = 0; t < 80; t++) begin
      case ($urandom_range(0, 9))
        0:       addr = 32'($urandom_range(0, WIN - 1) * 4 + $urandom_range(1, 3));
        1: begin
          case ($urandom_range(0, 3))
            0:       addr = 32'(DMEM_SIZE * 4);
            1:       addr = 32'hFFFF_FFFC;
            2:       addr = 32'h8000_0000 | 32'($urandom_range(0, WIN - 1) * 4);
            default: addr = 32'(DMEM_SIZE * 4) + 32'($urandom_range(0, WIN - 1) * 4);
          endcase
        end
        default: addr = 32'($urandom_range(0, WIN - 1) * 4);
      endcase
      exp_err = (addr[1:0] != 2'b00) || ((addr >> 2) >= 32'(DMEM_SIZE));
      if (exp_err && t % 7 == 0) addr = addr;  // keep error mix as drawn
      txn_a(1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom_range(0, 15)),
            $urandom_range(0, 2));
    end

    // Zero-latency responder: back-to-back, one transaction every 2 cycles
    b_if.rsp_ready = 1'b1;
    @(negedge CLK);
    for (int i = 0; i < 12; i++) begin
      b_if.req_valid = 1'b1;
      b_if.req_we    = (i < 4);
      b_if.req_addr  = 32'((i % 4) * 4);
      b_if.req_wdata = $urandom;
      b_if.req_be    = 4'hF;
      if (i < 4) ref_b[i] = b_if.req_wdata;
      check("b_ready", 32'(b_if.req_ready), 32'd1);
      @(negedge CLK);
      check("b_valid", 32'(b_if.rsp_valid), 32'd1);
      check("b_rdata", b_if.rsp_rdata, (i < 4) ? 32'h0 : ref_b[i % 4]);
      check("b_err", 32'(b_if.rsp_err), 32'd0);
      @(negedge CLK);
    end
    b_if.req_valid = 1'b0;
    @(negedge CLK);
    check("b_idle", 32'(busy_b), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
